// File: rtl/div_clk_monitor_if.sv
// Divided-clock monitor bus: the divider/stimulus side is the master, the monitor is the slave.
interface div_clk_monitor_if #(
   parameter int CNT_W = 8
);
   logic             div_clk_in;
   logic             clr_fault;
   logic             tick_out;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             locked;
   logic             fault;
   logic [7:0]       err_count;
   logic             duty_err;

   modport master (
      output div_clk_in, clr_fault,
      input  tick_out, period, period_valid, locked, fault, err_count, duty_err
   );

   modport slave (
      input  div_clk_in, clr_fault,
      output tick_out, period, period_valid, locked, fault, err_count, duty_err
   );
endinterface

// File: rtl/div_clk_monitor.sv
// Period/lock/fault monitor for the divided clock; tick source for timekeeping.
// Optional high-time (duty) check enabled by defining DUTY_CHECK_EN.
//
// state     | meaning
// S_IDLE    | no reference edge yet; next rise starts measuring
// S_MEASURE | counting consecutive good periods towards lock
// S_LOCKED  | locked; any bad period or timeout raises a fault
// S_FAULT   | fault taken from lock; next rise resumes measuring
module div_clk_monitor #(
   parameter int EXP_PERIOD = 6,
   parameter int TOL        = 0,
   parameter int LOCK_COUNT = 4,
   parameter int CNT_W      = 8
) (
   input logic              clk,
   input logic              rst,
   div_clk_monitor_if.slave bus
);

   localparam logic [CNT_W-1:0] EXP_P   = CNT_W'(EXP_PERIOD);
   localparam logic [CNT_W-1:0] TOL_P   = CNT_W'(TOL);
   localparam logic [CNT_W-1:0] TMO_P   = CNT_W'(EXP_PERIOD + TOL + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEASURE,
      S_LOCKED,
      S_FAULT
   } state_t;

   state_t           state;
   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] per_cnt;
   logic [3:0]       good_cnt;
   logic             tick_r;
   logic [CNT_W-1:0] period_r;
   logic             pv_r;
   logic             locked_r;
   logic             fault_r;
   logic [7:0]       err_r;
   logic             duty_err_r;
   logic             duty_bad;

   logic             rise;
   logic             timeout;
   logic [CNT_W-1:0] per_diff;
   logic             good;
   logic             eval_good;

   assign rise      = s1 & ~s2;
   assign timeout   = ~rise & (per_cnt == TMO_P);
   assign per_diff  = (per_cnt >= EXP_P) ? (per_cnt - EXP_P) : (EXP_P - per_cnt);
   assign good      = (per_diff <= TOL_P);
   assign eval_good = good & ~duty_bad;

`ifdef DUTY_CHECK_EN
   localparam int               HALF   = EXP_PERIOD / 2;
   localparam logic [CNT_W-1:0] HI_MIN = CNT_W'((HALF > TOL) ? (HALF - TOL) : 0);
   localparam logic [CNT_W-1:0] HI_MAX = CNT_W'(HALF + TOL);

   logic [CNT_W-1:0] hi_cnt;
   logic             fall;
   logic             duty_ok;

   assign fall    = ~s1 & s2;
   assign duty_ok = (hi_cnt >= HI_MIN) && (hi_cnt <= HI_MAX);

   // duty_bad is held from the offending fall until the next rise consumes it
   always_ff @(posedge clk) begin
      if (!rst) begin
         hi_cnt     <= '0;
         duty_bad   <= 1'b0;
         duty_err_r <= 1'b0;
      end else begin
         duty_err_r <= fall & ~duty_ok;
         if (rise)
            hi_cnt <= CNT_W'(1);
         else if (s1 && (hi_cnt != CNT_MAX))
            hi_cnt <= hi_cnt + CNT_W'(1);
         if (rise)
            duty_bad <= 1'b0;
         else if (fall && !duty_ok)
            duty_bad <= 1'b1;
      end
   end
`else
   assign duty_bad   = 1'b0;
   assign duty_err_r = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         s1       <= 1'b0;
         s2       <= 1'b0;
         per_cnt  <= '0;
         good_cnt <= '0;
         tick_r   <= 1'b0;
         period_r <= '0;
         pv_r     <= 1'b0;
         locked_r <= 1'b0;
         fault_r  <= 1'b0;
         err_r    <= '0;
      end else begin
         s1     <= bus.div_clk_in;
         s2     <= s1;
         tick_r <= rise;
         pv_r   <= 1'b0;
         if (rise)
            per_cnt <= CNT_W'(1);
         else if (per_cnt != CNT_MAX)
            per_cnt <= per_cnt + CNT_W'(1);

         // a fault raised below overrides a coincident clear
         if (bus.clr_fault)
            fault_r <= 1'b0;

         case (state)
            S_IDLE: begin
               if (rise) begin
                  state    <= S_MEASURE;
                  good_cnt <= '0;
               end
            end
            // good_cnt is held at 0 through LOCKED and FAULT, so FAULT restarts the count
            S_MEASURE, S_FAULT: begin
               if (rise) begin
                  period_r <= per_cnt;
                  pv_r     <= 1'b1;
                  if (eval_good) begin
                     if (good_cnt + 4'd1 == LOCK_N) begin
                        state    <= S_LOCKED;
                        locked_r <= 1'b1;
                        good_cnt <= '0;
                     end else begin
                        state    <= S_MEASURE;
                        good_cnt <= good_cnt + 4'd1;
                     end
                  end else begin
                     state    <= S_MEASURE;
                     good_cnt <= '0;
                  end
               end else if (timeout) begin
                  state    <= S_IDLE;
                  good_cnt <= '0;
               end
            end
            S_LOCKED: begin
               if (rise) begin
                  period_r <= per_cnt;
                  pv_r     <= 1'b1;
               end
               if ((rise && !eval_good) || timeout) begin
                  state    <= S_FAULT;
                  locked_r <= 1'b0;
                  fault_r  <= 1'b1;
                  if (err_r != 8'hFF)
                     err_r <= err_r + 8'd1;
               end
            end
            default: begin
               state    <= S_IDLE;
               good_cnt <= '0;
            end
         endcase
      end
   end

   assign bus.tick_out     = tick_r;
   assign bus.period       = period_r;
   assign bus.period_valid = pv_r;
   assign bus.locked       = locked_r;
   assign bus.fault        = fault_r;
   assign bus.err_count    = err_r;
   assign bus.duty_err     = duty_err_r;

endmodule
